// File: rtl/axis2dvp_pkg.sv
// axis2dvp shared types: FSM states, byte order and colour-bar values.
// Colour bars are used only when AXIS2DVP_TEST_PATTERN_EN is defined.
package axis2dvp_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_VSYNC,
      S_VBP,
      S_ACT,
      S_HBLANK,
      S_VFP
   } state_t;

   localparam bit HI_BYTE_FIRST = 1'b1;

   localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
   localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
   localparam logic [15:0] BAR_CYAN    = 16'h07FF;
   localparam logic [15:0] BAR_GREEN   = 16'h07E0;
   localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
   localparam logic [15:0] BAR_RED     = 16'hF800;
   localparam logic [15:0] BAR_BLUE    = 16'h001F;
   localparam logic [15:0] BAR_BLACK   = 16'h0000;

   function automatic logic [7:0] first_byte(
      input logic [15:0] px
   );
      return HI_BYTE_FIRST ? px[15:8] : px[7:0];
   endfunction

   function automatic logic [7:0] second_byte(
      input logic [15:0] px
   );
      return HI_BYTE_FIRST ? px[7:0] : px[15:8];
   endfunction

   function automatic logic [15:0] bar_rgb(
      input logic [2:0] bar
   );
      logic [15:0] c;
      unique case (bar)
         3'd0:    c = BAR_WHITE;
         3'd1:    c = BAR_YELLOW;
         3'd2:    c = BAR_CYAN;
         3'd3:    c = BAR_GREEN;
         3'd4:    c = BAR_MAGENTA;
         3'd5:    c = BAR_RED;
         3'd6:    c = BAR_BLUE;
         default: c = BAR_BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/axis2dvp_tpg.sv
// Colour-bar generator: pixel index in, RGB565 out.
// Instantiated only when AXIS2DVP_TEST_PATTERN_EN is defined.
module axis2dvp_tpg
   import axis2dvp_pkg::*;
#(
   parameter int H_ACT = 640,
   parameter int PW    = $clog2(H_ACT + 1)
) (
   input  logic [PW-1:0] pix,
   output logic [15:0]   rgb
);

   // narrow lines still get one pixel per bar
   localparam int BAR_W = (H_ACT >= 8) ? H_ACT / 8 : 1;

   logic [31:0] bar_idx;

   always_comb begin
      bar_idx = 32'(pix) / BAR_W;
      rgb     = (bar_idx > 32'd7) ? BAR_BLACK
                                  : bar_rgb(bar_idx[2:0]);
   end

endmodule

// File: rtl/axis2dvp.sv
// AXI4-Stream RGB565 to DVP byte stream with self-generated timing.
// AXIS2DVP_TEST_PATTERN_EN adds pattern_en and a colour-bar source.
module axis2dvp
   import axis2dvp_pkg::*;
#(
   parameter int H_ACT     = 640,
   parameter int V_ACT     = 480,
   parameter int H_BLANK   = 64,
   parameter int VSYNC_LEN = 16,
   parameter int V_BP      = 32,
   parameter int V_FP      = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] axis_tdata,
   input  logic        axis_tvalid,
   output logic        axis_tready,
   input  logic        axis_tuser,
   input  logic        axis_tlast,
   output logic        dvp_vsync,
   output logic        dvp_href,
   output logic [7:0]  dvp_data,
   output logic [15:0] frame_cnt,
   output logic [3:0]  status
`ifdef AXIS2DVP_TEST_PATTERN_EN
   ,
   input  logic        pattern_en
`endif
);

   localparam int PW   = $clog2(H_ACT + 1);
   localparam int LW   = $clog2(V_ACT + 1);
   localparam int TA   = VSYNC_LEN > V_BP ? VSYNC_LEN : V_BP;
   localparam int TB   = H_BLANK > V_FP ? H_BLANK : V_FP;
   localparam int TMAX = TA > TB ? TA : TB;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [TW-1:0] T_VS  = TW'(VSYNC_LEN - 1);
   localparam logic [TW-1:0] T_VBP = TW'(V_BP - 1);
   localparam logic [TW-1:0] T_HB  = TW'(H_BLANK - 1);
   localparam logic [TW-1:0] T_VFP = TW'(V_FP - 1);
   localparam logic [PW-1:0] PIX_LAST  = PW'(H_ACT - 1);
   localparam logic [LW-1:0] LINE_LAST = LW'(V_ACT - 1);

   state_t        state, state_d;
   logic [TW-1:0] tmr, tmr_d;
   logic [PW-1:0] pix, pix_d;
   logic [LW-1:0] line, line_d;
   logic          phase, phase_d;
   logic          frame_done;
   logic          pat_start;
   logic          pat_mode;
   logic [15:0]   pat_rgb;
   logic [15:0]   data_q;
   logic [2:0]    err_q;

`ifdef AXIS2DVP_TEST_PATTERN_EN
   logic pat_q;

   assign pat_start = pattern_en;
   assign pat_mode  = pat_q;

   always_ff @(posedge clk) begin
      if (reset)
         pat_q <= 1'b0;
      else if (state == S_IDLE)
         pat_q <= pattern_en;
   end

   axis2dvp_tpg #(
      .H_ACT (H_ACT),
      .PW    (PW)
   ) u_tpg (
      .pix (pix),
      .rgb (pat_rgb)
   );
`else
   assign pat_start = 1'b0;
   assign pat_mode  = 1'b0;
   assign pat_rgb   = 16'h0000;
`endif

   always_comb begin
      state_d     = state;
      tmr_d       = tmr;
      pix_d       = pix;
      line_d      = line;
      phase_d     = phase;
      frame_done  = 1'b0;
      axis_tready = 1'b0;
      unique case (state)
         S_IDLE: begin
            tmr_d   = '0;
            pix_d   = '0;
            line_d  = '0;
            phase_d = 1'b0;
            // SOF beat is left on the bus for pixel 0
            axis_tready = ~pat_start & axis_tvalid
                        & ~axis_tuser;
            if (pat_start | (axis_tvalid & axis_tuser))
               state_d = S_VSYNC;
         end
         S_VSYNC: begin
            tmr_d = tmr + 1'b1;
            if (tmr == T_VS) begin
               tmr_d   = '0;
               state_d = S_VBP;
            end
         end
         S_VBP: begin
            tmr_d = tmr + 1'b1;
            if (tmr == T_VBP) begin
               tmr_d   = '0;
               state_d = S_ACT;
            end
         end
         S_ACT: begin
            phase_d     = ~phase;
            axis_tready = ~phase & ~pat_mode;
            if (phase) begin
               pix_d = pix + 1'b1;
               if (pix == PIX_LAST) begin
                  pix_d   = '0;
                  state_d = S_HBLANK;
               end
            end
         end
         S_HBLANK: begin
            tmr_d = tmr + 1'b1;
            if (tmr == T_HB) begin
               tmr_d = '0;
               if (line == LINE_LAST) begin
                  line_d  = '0;
                  state_d = S_VFP;
               end else begin
                  line_d  = line + 1'b1;
                  state_d = S_ACT;
               end
            end
         end
         S_VFP: begin
            tmr_d = tmr + 1'b1;
            if (tmr == T_VFP) begin
               tmr_d      = '0;
               frame_done = 1'b1;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         tmr   <= '0;
         pix   <= '0;
         line  <= '0;
         phase <= 1'b0;
      end else begin
         state <= state_d;
         tmr   <= tmr_d;
         pix   <= pix_d;
         line  <= line_d;
         phase <= phase_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dvp_vsync <= 1'b0;
         dvp_href  <= 1'b0;
         dvp_data  <= '0;
         data_q    <= '0;
         frame_cnt <= '0;
         err_q     <= '0;
      end else begin
         dvp_vsync <= (state == S_VSYNC);
         dvp_href  <= (state == S_ACT);
         dvp_data  <= '0;
         if (frame_done)
            frame_cnt <= frame_cnt + 16'd1;
         if (state == S_ACT) begin
            if (phase) begin
               dvp_data <= second_byte(data_q);
            end else if (pat_mode) begin
               data_q   <= pat_rgb;
               dvp_data <= first_byte(pat_rgb);
            end else if (axis_tvalid) begin
               data_q   <= axis_tdata;
               dvp_data <= first_byte(axis_tdata);
               if (axis_tuser && (pix != '0 || line != '0))
                  err_q[1] <= 1'b1;
               if (axis_tlast != (pix == PIX_LAST))
                  err_q[2] <= 1'b1;
            end else begin
               // missing beat: slot stays, pixel is dropped
               data_q   <= '0;
               err_q[0] <= 1'b1;
            end
         end
      end
   end

   assign status = {state != S_IDLE, err_q};

endmodule

// File: tb/tb_axis2dvp.sv
// Directed bench for axis2dvp on a tiny 4x2 raster.
// Built without AXIS2DVP_TEST_PATTERN_EN.
module tb_axis2dvp;

   localparam int H_ACT     = 4;
   localparam int V_ACT     = 2;
   localparam int H_BLANK   = 3;
   localparam int VSYNC_LEN = 2;
   localparam int V_BP      = 2;
   localparam int V_FP      = 2;
   localparam int LINE_T    = 2 * H_ACT + H_BLANK;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] axis_tdata = '0;
   logic        axis_tvalid = 1'b0;
   logic        axis_tready;
   logic        axis_tuser = 1'b0;
   logic        axis_tlast = 1'b0;
   logic        dvp_vsync;
   logic        dvp_href;
   logic [7:0]  dvp_data;
   logic [15:0] frame_cnt;
   logic [3:0]  status;

   int n_chk = 0;
   int n_fail = 0;

   logic [15:0] bd[$];
   logic        bu[$];
   logic        bl[$];
   logic        vs_q[$];
   logic        hr_q[$];
   logic [7:0]  got[$];
   int          idx;
   int          gap_at;
   bit          gap_done;

   always #5 clk = ~clk;

   axis2dvp #(
      .H_ACT     (H_ACT),
      .V_ACT     (V_ACT),
      .H_BLANK   (H_BLANK),
      .VSYNC_LEN (VSYNC_LEN),
      .V_BP      (V_BP),
      .V_FP      (V_FP)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .axis_tdata  (axis_tdata),
      .axis_tvalid (axis_tvalid),
      .axis_tready (axis_tready),
      .axis_tuser  (axis_tuser),
      .axis_tlast  (axis_tlast),
      .dvp_vsync   (dvp_vsync),
      .dvp_href    (dvp_href),
      .dvp_data    (dvp_data),
      .frame_cnt   (frame_cnt),
      .status      (status)
   );

   task automatic check(
      input string        tag,
      input logic [127:0] obs,
      input logic [127:0] exp
   );
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset       = 1'b1;
      axis_tvalid = 1'b0;
      axis_tuser  = 1'b0;
      axis_tlast  = 1'b0;
      axis_tdata  = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   task automatic new_stream();
      bd.delete();
      bu.delete();
      bl.delete();
      vs_q.delete();
      hr_q.delete();
      got.delete();
      idx      = 0;
      gap_at   = -1;
      gap_done = 1'b0;
   endtask

   task automatic push_beat(
      input logic [15:0] d,
      input logic        u,
      input logic        l
   );
      bd.push_back(d);
      bu.push_back(u);
      bl.push_back(l);
   endtask

   task automatic load_frame(
      input int tl_bad,
      input int tu_bad
   );
      for (int k = 0; k < H_ACT * V_ACT; k++)
         push_beat(16'h1100 + 16'(k),
                   (k == 0) || (k == tu_bad),
                   (k % H_ACT == H_ACT - 1) ||
                   (k == tl_bad));
   endtask

   // one cycle per iteration: log outputs, drive, see handshake
   task automatic run(input int n);
      repeat (n) begin
         @(negedge clk);
         vs_q.push_back(dvp_vsync);
         hr_q.push_back(dvp_href);
         if (dvp_href)
            got.push_back(dvp_data);
         if (idx < bd.size()) begin
            axis_tvalid = !(idx == gap_at && !gap_done);
            axis_tdata  = bd[idx];
            axis_tuser  = bu[idx];
            axis_tlast  = bl[idx];
         end else begin
            axis_tvalid = 1'b0;
            axis_tuser  = 1'b0;
            axis_tlast  = 1'b0;
         end
         #1;
         if (axis_tvalid && axis_tready) begin
            idx++;
         end else if (!axis_tvalid && axis_tready &&
                      idx == gap_at && !gap_done) begin
            gap_done = 1'b1;
            idx++;
         end
      end
   endtask

   task automatic check_frame(
      input string tag,
      input int    hole
   );
      int           t0;
      logic [31:0]  vs_o, hr_o, vs_e, hr_e;
      logic [127:0] b_o, b_e;
      t0 = -1;
      for (int i = 0; i < vs_q.size(); i++)
         if (vs_q[i] && t0 < 0)
            t0 = i;
      for (int k = 0; k < 32; k++) begin
         if (t0 >= 0 && t0 + k < vs_q.size()) begin
            vs_o[k] = vs_q[t0 + k];
            hr_o[k] = hr_q[t0 + k];
         end else begin
            vs_o[k] = 1'bx;
            hr_o[k] = 1'bx;
         end
         vs_e[k] = (k < VSYNC_LEN);
         hr_e[k] = 1'b0;
         for (int l = 0; l < V_ACT; l++) begin
            int s;
            s = VSYNC_LEN + V_BP + l * LINE_T;
            if (k >= s && k < s + 2 * H_ACT)
               hr_e[k] = 1'b1;
         end
      end
      check({tag, "_vsync"}, 128'(vs_o), 128'(vs_e));
      check({tag, "_href"}, 128'(hr_o), 128'(hr_e));
      b_o = '0;
      b_e = '0;
      for (int i = 0; i < got.size() && i < 16; i++)
         b_o[127 - 8 * i -: 8] = got[i];
      for (int k = 0; k < 8; k++)
         if (k != hole)
            b_e[127 - 16 * k -: 16] = 16'h1100 + 16'(k);
      check({tag, "_nbytes"}, 128'(got.size()), 128'd16);
      check({tag, "_bytes"}, b_o, b_e);
   endtask

   initial begin
      do_reset();
      check("reset_outputs",
            128'({dvp_vsync, dvp_href, dvp_data,
                  frame_cnt, status}),
            128'd0);
      check("reset_tready", 128'(axis_tready), 128'd0);

      new_stream();
      load_frame(-1, -1);
      run(40);
      check_frame("normal", -1);
      check("normal_frame_cnt", 128'(frame_cnt), 128'd1);
      check("normal_status", 128'(status), 128'd0);

      new_stream();
      push_beat(16'hDEAD, 1'b0, 1'b0);
      push_beat(16'hBEEF, 1'b0, 1'b1);
      push_beat(16'hCAFE, 1'b0, 1'b0);
      load_frame(-1, -1);
      run(3);
      check("junk_accepted", 128'(idx), 128'd3);
      check("junk_idle",
            128'({status[3], dvp_vsync}), 128'd0);
      run(40);
      check_frame("after_junk", -1);
      check("junk_frame_cnt", 128'(frame_cnt), 128'd2);
      check("junk_status", 128'(status), 128'd0);

      do_reset();
      new_stream();
      gap_at = 2;
      load_frame(-1, -1);
      run(40);
      check_frame("underflow", 2);
      check("underflow_status", 128'(status), 128'h1);
      check("underflow_frame_cnt",
            128'(frame_cnt), 128'd1);

      new_stream();
      load_frame(2, 4);
      run(40);
      check_frame("errors", -1);
      check("errors_status", 128'(status), 128'h7);
      check("errors_frame_cnt", 128'(frame_cnt), 128'd2);

      new_stream();
      load_frame(-1, -1);
      run(10);
      check("busy_mid", 128'(status[3]), 128'd1);
      do_reset();
      check("midreset_outputs",
            128'({dvp_vsync, dvp_href, dvp_data,
                  axis_tready, frame_cnt, status}),
            128'd0);
      new_stream();
      push_beat(16'h2222, 1'b0, 1'b0);
      run(1);
      check("midreset_drop", 128'(idx), 128'd1);
      run(6);
      begin
         logic act;
         act = status[3];
         foreach (vs_q[i])
            act = act | vs_q[i] | hr_q[i];
         check("midreset_no_restart", 128'(act), 128'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
